// File: rtl/fetch_pkg.sv
// Shared types and helpers for the fetch PC sequencer: state encoding,
// default memory map and the fetch-address legality check.
package fetch_pkg;

  localparam int               PC_W         = 32;
  localparam logic [PC_W-1:0]  RESET_PC_DEF = 32'h0000_3000;
  localparam int               IM_WORDS_DEF = 1024;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FAULT = 2'd2
  } state_e;

  // Word-aligned and inside [base, last] with an unsigned compare.
  function automatic logic addr_legal(input logic [PC_W-1:0] a,
                                      input logic [PC_W-1:0] base,
                                      input logic [PC_W-1:0] last);
    return (a[1:0] == 2'b00) && (a >= base) && (a <= last);
  endfunction

endpackage

// File: rtl/fetch_redir_buf.sv
// One-entry pending-redirect register: holds the newest redirect seen while
// fetch is frozen, released when the stall lifts, flushed on reset.
module fetch_redir_buf
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            i_capture,
  input  logic [PC_W-1:0] i_target,
  input  logic            i_consume,
  output logic            o_pend_v,
  output logic [PC_W-1:0] o_pend_pc
);

  logic            r_pend_v;
  logic [PC_W-1:0] r_pend_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_v  <= 1'b0;
      r_pend_pc <= '0;
    end else if (i_capture) begin
      // Newest redirect overwrites any older one still waiting.
      r_pend_v  <= 1'b1;
      r_pend_pc <= i_target;
    end else if (i_consume) begin
      r_pend_v  <= 1'b0;
    end
  end

  assign o_pend_v  = r_pend_v;
  assign o_pend_pc = r_pend_pc;

endmodule

// File: rtl/fetch_seq.sv
// Next-PC sequencer owning the architectural fetch PC: sequential advance,
// stall hold, redirects and a sticky fault trap on illegal fetch addresses.
// Optional performance counters are enabled with `define FETCH_SEQ_PERF_EN.
module fetch_seq
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          IM_WORDS = IM_WORDS_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redir_valid,
  input  logic [31:0] redir_target,
  output logic [31:0] pc,
  output logic [31:0] npc,
  output logic        fetch_valid,
  output logic        fault,
  output logic [31:0] fault_pc
`ifdef FETCH_SEQ_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] redir_cnt
`endif
);

  localparam logic [PC_W-1:0] LAST_PC = RESET_PC + PC_W'(4 * IM_WORDS) - PC_W'(4);

  state_e          r_state;
  state_e          w_state_next;
  logic [PC_W-1:0] r_pc;
  logic            r_fault;
  logic [PC_W-1:0] r_fault_pc;

  logic [PC_W-1:0] w_npc;
  logic            w_in_fault;
  logic            w_hold;
  logic            w_trap;
  logic            w_pend_v;
  logic [PC_W-1:0] w_pend_pc;
  logic            w_capture;
  logic            w_consume;

  assign w_in_fault = (r_state == FAULT);
  assign w_hold     = w_in_fault | stall;
  // A stall holds the PC, so a same-cycle redirect must be parked.
  assign w_capture  = !w_in_fault && stall && redir_valid;
  assign w_consume  = !w_hold && w_pend_v;

  fetch_redir_buf u_redir_buf (
    .clk       (clk),
    .reset     (reset),
    .i_capture (w_capture),
    .i_target  (redir_target),
    .i_consume (w_consume),
    .o_pend_v  (w_pend_v),
    .o_pend_pc (w_pend_pc)
  );

  always_comb begin
    w_npc        = r_pc + PC_W'(4);
    w_trap       = 1'b0;
    w_state_next = r_state;

    if (w_hold) begin
      w_npc = r_pc;
    end else if (w_pend_v) begin
      w_npc = w_pend_pc;
    end else if (redir_valid) begin
      w_npc = redir_target;
    end

    w_trap = !w_hold && !addr_legal(w_npc, RESET_PC, LAST_PC);

    if (w_in_fault || w_trap) begin
      w_state_next = FAULT;
    end else if (stall) begin
      w_state_next = STALL;
    end else begin
      w_state_next = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= RUN;
      r_pc       <= RESET_PC;
      r_fault    <= 1'b0;
      r_fault_pc <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_npc;
      if (w_trap) begin
        r_fault    <= 1'b1;
        r_fault_pc <= w_npc;
      end
    end
  end

  assign pc          = r_pc;
  assign npc         = w_npc;
  assign fetch_valid = !w_in_fault;
  assign fault       = r_fault;
  assign fault_pc    = r_fault_pc;

`ifdef FETCH_SEQ_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_redir_cnt;
  logic        w_redir_applied;

  assign w_redir_applied = !w_hold && (w_pend_v || redir_valid);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_redir_cnt <= '0;
    end else begin
      if (r_state == STALL && r_stall_cnt != 32'hFFFF_FFFF) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (w_redir_applied && r_redir_cnt != 32'hFFFF_FFFF) begin
        r_redir_cnt <= r_redir_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign redir_cnt = r_redir_cnt;
`endif

endmodule

// File: tb/tb_fetch_seq.sv
// Scoreboard bench for fetch_seq: a reference model predicts pc/fault per
// cycle, expectations are queued at drive time and popped after the edge.
module tb_fetch_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redir_valid;
  logic [31:0] redir_target;
  logic [31:0] pc;
  logic [31:0] npc;
  logic        fetch_valid;
  logic        fault;
  logic [31:0] fault_pc;
`ifdef FETCH_SEQ_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] redir_cnt;
`endif

  fetch_seq dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .redir_valid  (redir_valid),
    .redir_target (redir_target),
    .pc           (pc),
    .npc          (npc),
    .fetch_valid  (fetch_valid),
    .fault        (fault),
    .fault_pc     (fault_pc)
`ifdef FETCH_SEQ_PERF_EN
    ,
    .stall_cnt    (stall_cnt),
    .redir_cnt    (redir_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        fault;
    logic [31:0] fault_pc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  // Reference model state (text segment 0x3000..0x3FFC).
  logic [31:0] m_pc       = 32'h0;
  logic        m_fault    = 1'b0;
  logic [31:0] m_fault_pc = 32'h0;
  logic        m_pend_v   = 1'b0;
  logic [31:0] m_pend_pc  = 32'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= 32'h0000_3000) && (a <= 32'h0000_3FFC);
  endfunction

  task automatic cycle(input logic rst, input logic st, input logic rv, input logic [31:0] tgt);
    logic [31:0] nxt;
    exp_t        e;
    reset        = rst;
    stall        = st;
    redir_valid  = rv;
    redir_target = tgt;
    #1;
    if (m_fault || st)  nxt = m_pc;
    else if (m_pend_v)  nxt = m_pend_pc;
    else if (rv)        nxt = tgt;
    else                nxt = m_pc + 32'd4;
    if (!rst) check("npc", npc, nxt);

    if (rst) begin
      m_pc = 32'h3000; m_fault = 1'b0; m_fault_pc = 32'h0;
      m_pend_v = 1'b0; m_pend_pc = 32'h0;
    end else if (!m_fault) begin
      if (!st && !legal(nxt)) begin
        m_fault    = 1'b1;
        m_fault_pc = nxt;
      end
      if (st && rv) begin
        m_pend_v  = 1'b1;
        m_pend_pc = tgt;
      end else if (!st) begin
        m_pend_v = 1'b0;
      end
      m_pc = nxt;
    end
    e.pc = m_pc; e.fault = m_fault; e.fault_pc = m_fault_pc;
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("pc", pc, e.pc);
    check("fault", {31'b0, fault}, {31'b0, e.fault});
    check("fetch_valid", {31'b0, fetch_valid}, {31'b0, !e.fault});
    check("fault_pc", fault_pc, e.fault_pc);
    $display("txn rst=%0b stall=%0b rv=%0b tgt=%08h -> pc=%08h fault=%0b fault_pc=%08h",
             rst, st, rv, tgt, pc, fault, fault_pc);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redir_valid = 1'b0; redir_target = 32'h0;
    @(posedge clk);
    #1;

    // Reset then free-running fetch.
    cycle(1, 0, 0, 32'h0);
    check("reset_pc", pc, 32'h0000_3000);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 32'h0);
    check("seq_pc", pc, 32'h0000_3010);

    // Direct redirect, one-cycle latency.
    cycle(0, 0, 1, 32'h3100);
    check("redir_pc", pc, 32'h0000_3100);
    cycle(0, 0, 0, 32'h0);

    // Stall with two redirects (newest wins), ignored redirect on release.
    cycle(0, 0, 1, 32'h3020);
    cycle(0, 1, 1, 32'h3200);
    cycle(0, 1, 1, 32'h3300);
    cycle(0, 1, 0, 32'h0);
    check("stall_hold", pc, 32'h0000_3020);
    cycle(0, 0, 1, 32'h3400);
    check("release_pc", pc, 32'h0000_3300);
    cycle(0, 0, 0, 32'h0);
    check("after_release", pc, 32'h0000_3304);

    // Reset while a redirect is pending must discard it.
    cycle(0, 1, 1, 32'h3800);
    cycle(1, 1, 0, 32'h0);
    cycle(0, 0, 0, 32'h0);
    check("flush_pend", pc, 32'h0000_3004);

    // Misaligned redirect traps; fault state is absorbing.
    cycle(0, 0, 1, 32'h3102);
    for (int i = 0; i < 10; i++) cycle(0, 1'($urandom_range(0, 1)), 1, 32'h3200);
    check("fault_frozen", pc, 32'h0000_3102);
    check("fault_pc_mis", fault_pc, 32'h0000_3102);

    // Sequential run off the end of the text segment.
    cycle(1, 0, 0, 32'h0);
    cycle(0, 0, 1, 32'h3FF8);
    cycle(0, 0, 0, 32'h0);
    cycle(0, 0, 0, 32'h0);
    check("wrap_fault_pc", fault_pc, 32'h0000_4000);
    cycle(1, 0, 0, 32'h0);
    check("wrap_reset", pc, 32'h0000_3000);

    // Below-range redirect.
    cycle(0, 0, 1, 32'h2FFC);
    check("low_fault", {31'b0, fault}, 32'd1);
    cycle(1, 0, 0, 32'h0);

    // Random mix of stalls and legal redirects.
    for (int i = 0; i < 60; i++) begin
      cycle(0, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
            32'h3000 + (32'($urandom_range(0, 1023)) << 2));
    end

`ifdef FETCH_SEQ_PERF_EN
    cycle(1, 0, 0, 32'h0);
    check("stall_cnt_rst", stall_cnt, 32'd0);
    check("redir_cnt_rst", redir_cnt, 32'd0);
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 32'h0);
    cycle(0, 0, 1, 32'h3500);
    cycle(0, 0, 1, 32'h3600);
    cycle(0, 0, 0, 32'h0);
    check("stall_cnt", stall_cnt, 32'd5);
    check("redir_cnt", redir_cnt, 32'd2);
    cycle(1, 0, 0, 32'h0);
    check("stall_cnt_clr", stall_cnt, 32'd0);
    check("redir_cnt_clr", redir_cnt, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
